// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters; round-robin grant, operands held for execute time.
// Latency: accept -> rsp_valid_o is 2 cycles (non-MUL), 1+MUL_CYCLES cycles (MUL).
// Backpressure: rsp_ready_i low holds RESP with stable outputs; no grant until IDLE again.

module alu_share_alu (
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [3:0]  ctrl,
  output logic [31:0] result,
  output logic        zero
);

  // Combinational ALU; unlisted control codes yield zero
  always_comb begin
    result = '0;
    case (ctrl)
      4'b0000: result = src1 & src2;
      4'b0001: result = src1 | src2;
      4'b0010: result = src1 + src2;
      4'b0110: result = src1 - src2;
      4'b0111: result = {31'd0, (src1 < src2)};
      4'b1100: result = ~(src1 | src2);
      4'b1111: result = src1 * src2;
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

module alu_share_ctrl #(
  parameter int MUL_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_src1_i,
  input  logic [31:0] req0_src2_i,
  input  logic [3:0]  req0_ctrl_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_src1_i,
  input  logic [31:0] req1_src2_i,
  input  logic [3:0]  req1_ctrl_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_id_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_zero_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CTRL_MUL = 4'b1111;
  // Counter preload so that EXEC lasts exactly MUL_CYCLES cycles for MUL
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t      state;
  logic        last_grant;
  logic [3:0]  cnt;
  logic [31:0] op_src1;
  logic [31:0] op_src2;
  logic [3:0]  op_ctrl;
  logic        op_id;

  logic        grant_vld;
  logic        grant_id;
  logic [31:0] sel_src1;
  logic [31:0] sel_src2;
  logic [3:0]  sel_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;

  // Grant decision: single requester wins outright, a tie goes to the one not granted last
  always_comb begin
    grant_id  = (req0_valid_i && req1_valid_i) ? ~last_grant : req1_valid_i;
    grant_vld = (state == ST_IDLE) && (req0_valid_i || req1_valid_i) && !rst_i;
    sel_src1  = grant_id ? req1_src1_i : req0_src1_i;
    sel_src2  = grant_id ? req1_src2_i : req0_src2_i;
    sel_ctrl  = grant_id ? req1_ctrl_i : req0_ctrl_i;
  end

  assign req0_ready_o = grant_vld && !grant_id;
  assign req1_ready_o = grant_vld && grant_id;

  // The ALU only ever sees the latched operands, so requester changes after accept are ignored
  alu_share_alu u_alu (
    .src1   (op_src1),
    .src2   (op_src2),
    .ctrl   (op_ctrl),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Sequencer FSM with registered response and busy outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      cnt         <= 4'd0;
      op_src1     <= '0;
      op_src2     <= '0;
      op_ctrl     <= '0;
      op_id       <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= 1'b0;
      rsp_data_o  <= '0;
      rsp_zero_o  <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            op_src1 <= sel_src1;
            op_src2 <= sel_src2;
            op_ctrl <= sel_ctrl;
            op_id   <= grant_id;
            cnt     <= (sel_ctrl == CTRL_MUL) ? MUL_LOAD : 4'd0;
            busy_o  <= 1'b1;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_data_o  <= alu_result;
            rsp_zero_o  <= alu_zero;
            rsp_id_o    <= op_id;
            rsp_valid_o <= 1'b1;
            last_grant  <= op_id;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_o <= 1'b0;
          busy_o      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: reset, arbitration, MUL timing, backpressure, mid-op reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Every wait on the DUT is bounded and a timeout shows up as a failed comparison.

module tb_alu_share_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i;
  logic [3:0]  req0_ctrl_i, req1_ctrl_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_id_o, rsp_zero_o, busy_o;
  logic [31:0] rsp_data_o;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk_i = ~clk_i;

  alu_share_ctrl #(.MUL_CYCLES(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_src1_i  (req0_src1_i),
    .req0_src2_i  (req0_src2_i),
    .req0_ctrl_i  (req0_ctrl_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_src1_i  (req1_src1_i),
    .req1_src2_i  (req1_src2_i),
    .req1_ctrl_i  (req1_ctrl_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_zero_o   (rsp_zero_o),
    .busy_o       (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request (call right after a rising edge), wait for its grant, drop valid after accept
  task automatic issue(input logic id, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b, output int waited);
    int n;
    if (id) begin
      req1_valid_i = 1'b1; req1_ctrl_i = c; req1_src1_i = a; req1_src2_i = b;
    end else begin
      req0_valid_i = 1'b1; req0_ctrl_i = c; req0_src1_i = a; req0_src2_i = b;
    end
    n = 0;
    @(negedge clk_i);
    while (!(id ? req1_ready_o : req0_ready_o) && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    waited = n;
    chk("accept", 32'(id ? req1_ready_o : req0_ready_o), 32'd1);
    @(posedge clk_i); #1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
  endtask

  // Called right after the accepting edge; checks latency and payload, then handshakes
  task automatic expect_rsp(input string tag, input logic id, input logic [31:0] data,
                            input logic zero, input int lat);
    int n;
    n = 1;
    @(negedge clk_i);
    while (!rsp_valid_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_lat"},  32'(n), 32'(lat));
    chk({tag, "_data"}, rsp_data_o, data);
    chk({tag, "_zero"}, 32'(rsp_zero_o), 32'(zero));
    chk({tag, "_id"},   32'(rsp_id_o), 32'(id));
    @(posedge clk_i); #1;
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  w;
    bit  seen;
    rst_i = 1'b1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    req0_src1_i = '0; req0_src2_i = '0; req0_ctrl_i = '0;
    req1_src1_i = '0; req1_src2_i = '0; req1_ctrl_i = '0;
    rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_rdy0",  32'(req0_ready_o), 32'd0);
    chk("rst_rdy1",  32'(req1_ready_o), 32'd0);
    chk("rst_data",  rsp_data_o, 32'd0);
    chk("rst_zero",  32'(rsp_zero_o), 32'd0);
    chk("rst_id",    32'(rsp_id_o), 32'd0);
    @(posedge clk_i); #1;

    // req0 ADD 5+7 alone: granted in the first cycle, response two cycles later
    issue(1'b0, 4'b0010, 32'd5, 32'd7, w);
    chk("add_first_cycle", 32'(w), 32'd0);
    expect_rsp("add", 1'b0, 32'd12, 1'b0, 2);

    // Both requesters valid every cycle: grants alternate starting at 0 after reset
    reset_dut();
    req0_valid_i = 1'b1; req0_ctrl_i = 4'b0110; req0_src1_i = 32'd9;    req0_src2_i = 32'd9;
    req1_valid_i = 1'b1; req1_ctrl_i = 4'b0001; req1_src1_i = 32'h0000_00F0; req1_src2_i = 32'h0000_000F;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      @(negedge clk_i);
      while (!(req0_ready_o || req1_ready_o) && n < 20) begin
        @(negedge clk_i);
        n++;
      end
      chk("rr_onehot", 32'(req0_ready_o && req1_ready_o), 32'd0);
      chk("rr_grant",  32'(req1_ready_o), 32'(k % 2));
      @(posedge clk_i); #1;
      if (k % 2 == 0) expect_rsp("rr_sub", 1'b0, 32'd0, 1'b1, 2);
      else            expect_rsp("rr_or",  1'b1, 32'h0000_00FF, 1'b0, 2);
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;

    // MUL 0x10000*0x10000 truncates to 0; response 5 cycles after accept
    issue(1'b1, 4'b1111, 32'h0001_0000, 32'h0001_0000, w);
    expect_rsp("mul_wrap", 1'b1, 32'd0, 1'b1, 5);
    issue(1'b0, 4'b1111, 32'd7, 32'd6, w);
    expect_rsp("mul_42", 1'b0, 32'd42, 1'b0, 5);

    // Operands changed after accept must not affect the result
    issue(1'b0, 4'b0010, 32'd100, 32'd200, w);
    req0_src1_i = 32'd0;
    req0_ctrl_i = 4'b0000;
    expect_rsp("late_change", 1'b0, 32'd300, 1'b0, 2);

    // Backpressure: RESP held for 6 cycles while req0 waits with new operands
    rsp_ready_i = 1'b0;
    issue(1'b0, 4'b0010, 32'd1, 32'd2, w);
    w = 0;
    @(negedge clk_i);
    while (!rsp_valid_o && w < 40) begin
      @(negedge clk_i);
      w++;
    end
    req0_valid_i = 1'b1; req0_ctrl_i = 4'b0010; req0_src1_i = 32'd10; req0_src2_i = 32'd20;
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", 32'(rsp_valid_o), 32'd1);
      chk("bp_data",  rsp_data_o, 32'd3);
      chk("bp_id",    32'(rsp_id_o), 32'd0);
      chk("bp_zero",  32'(rsp_zero_o), 32'd0);
      chk("bp_rdy0",  32'(req0_ready_o), 32'd0);
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("bp_idle_valid", 32'(rsp_valid_o), 32'd0);
    chk("bp_idle_rdy0",  32'(req0_ready_o), 32'd1);
    @(posedge clk_i); #1;
    req0_valid_i = 1'b0;
    expect_rsp("bp_new", 1'b0, 32'd30, 1'b0, 2);

    // Reset in the second EXEC cycle of a MUL discards it
    issue(1'b1, 4'b1111, 32'd3, 32'd4, w);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("mrst_busy",  32'(busy_o), 32'd0);
    chk("mrst_valid", 32'(rsp_valid_o), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) seen = 1'b1;
    end
    chk("mrst_no_rsp", 32'(seen), 32'd0);
    @(posedge clk_i); #1;
    req0_valid_i = 1'b1; req0_ctrl_i = 4'b0000; req0_src1_i = 32'hFF; req0_src2_i = 32'h0F;
    req1_valid_i = 1'b1; req1_ctrl_i = 4'b1100; req1_src1_i = 32'd0;  req1_src2_i = 32'd0;
    @(negedge clk_i);
    chk("mrst_tie_rdy0", 32'(req0_ready_o), 32'd1);
    chk("mrst_tie_rdy1", 32'(req1_ready_o), 32'd0);
    @(posedge clk_i); #1;
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    expect_rsp("mrst_and", 1'b0, 32'h0000_000F, 1'b0, 2);

    // Remaining codes: SLT unsigned, SUB wrap, NOR, unlisted code
    issue(1'b0, 4'b0111, 32'd3, 32'hFFFF_FFFF, w);
    expect_rsp("slt", 1'b0, 32'd1, 1'b0, 2);
    issue(1'b1, 4'b0110, 32'd3, 32'd5, w);
    expect_rsp("sub_neg", 1'b1, 32'hFFFF_FFFE, 1'b0, 2);
    issue(1'b1, 4'b1100, 32'd0, 32'd0, w);
    expect_rsp("nor", 1'b1, 32'hFFFF_FFFF, 1'b0, 2);
    issue(1'b1, 4'b1010, 32'd5, 32'd6, w);
    expect_rsp("illegal", 1'b1, 32'd0, 1'b1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and arbiter that shares one ALU instance between two requesters (e.g. the integer pipeline and a multiply/divide helper). It accepts operations over valid/ready handshakes and grants them round-robin. It holds operands stable for the operation's execute time, including a multi-cycle MUL, and returns a registered result tagged with the requester ID. The block contains the ALU instance and is the only driver of its inputs.

## Interface
- MUL_CYCLES, 4, execute cycles for ctrl 4'b1111 (MUL); legal range 1..15
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- req0_valid_i  in  1  requester 0 has an operation
- req0_ready_o  out  1  requester 0 operation accepted this cycle
- req0_src1_i / req0_src2_i  in  32  requester 0 operands
- req0_ctrl_i  in  4  requester 0 ALU control code
- req1_valid_i, req1_ready_o, req1_src1_i, req1_src2_i, req1_ctrl_i  same as requester 0
- rsp_valid_o  out  1  result available
- rsp_ready_i  in  1  consumer takes result
- rsp_id_o  out  1  requester that issued the result
- rsp_data_o  out  32  registered ALU result
- rsp_zero_o  out  1  registered ALU zero flag
- busy_o  out  1  high in any state other than IDLE

## Operation
- ALU codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (unsigned compare), 1100 NOR, 1111 MUL (low 32 bits). Any other code gives result 0 and zero 1. Unlisted codes are accepted, not rejected.
- The FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If one requester is valid, it is granted.
  - If both are valid, the requester not granted last wins (round-robin).
  - The grant raises that requester's reqN_ready_o combinationally in the same cycle.
  - The block latches src1, src2, ctrl and the ID.
  - It loads the cycle counter with MUL_CYCLES-1 for MUL, otherwise 0, and moves to EXEC.
  - With no valid request it stays in IDLE.
- EXEC:
  - The ALU is driven only from the latched operand registers.
  - While the counter is nonzero, it decrements and the FSM stays in EXEC.
  - When the counter is 0, the block captures the ALU result and zero flag into the response registers, updates last_grant to the latched ID, and moves to RESP.
- RESP:
  - rsp_valid_o is held high.
  - rsp_data_o, rsp_zero_o and rsp_id_o stay stable until rsp_valid_o && rsp_ready_i, then the FSM returns to IDLE.
- reqN_ready_o is low in EXEC and RESP, and at most one ready is high in any cycle.
- A request dropped before acceptance is never executed. Operands changing after acceptance have no effect.

## Timing
- Reset, with rst_i sampled high at an edge:
  - State becomes IDLE.
  - last_grant becomes 1, so requester 0 wins the first tie.
  - The counter is cleared.
  - rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o, busy_o, req0_ready_o and req1_ready_o are all 0.
- Reset mid-operation (EXEC or RESP) discards the operation. No response is produced, and the next cycle is IDLE with the reset values.
- Latency, from the acceptance edge t to the first cycle with rsp_valid_o high:
  - Non-MUL: EXEC at t+1, rsp_valid_o high at t+2.
  - MUL: rsp_valid_o high at t+1+MUL_CYCLES.
- Throughput is at most one operation per 3 cycles; IDLE is always visited between operations.
- Backpressure: rsp_ready_i low holds RESP indefinitely, with outputs stable and no new grant.
- Simultaneous events:
  - A handshake in RESP returns the FSM to IDLE. A pending request is granted in that IDLE cycle, not in RESP.
- rsp_zero_o is 1 iff the captured 32-bit result equals 0.
- The MUL result is truncated to 32 bits.

## Test plan
- Reset, then req0 ADD 5+7 alone with rsp_ready_i=1:
  - req0_ready_o is high in the first cycle.
  - rsp_valid_o is high 2 cycles later with rsp_data_o=12, rsp_zero_o=0, rsp_id_o=0.
- Both valid every cycle, SUB 9-9 from req0 and OR 0xF0|0x0F from req1:
  - Grants alternate 0,1,0,1.
  - Responses are 0 with zero=1, then 0xFF with zero=0.
- With MUL_CYCLES=4, req1 MUL 0x10000*0x10000:
  - The result is 0 and rsp_zero_o=1.
  - rsp_valid_o rises exactly 5 cycles after acceptance.
- Hold rsp_ready_i=0 for 6 cycles in RESP while req0 is valid with new operands:
  - rsp outputs do not change and req0_ready_o stays 0.
  - After rsp_ready_i rises, req0 is accepted in the following IDLE cycle.
- Pulse rst_i in the second EXEC cycle of a MUL:
  - The next cycle is IDLE and rsp_valid_o stays 0.
  - A subsequent tie is won by requester 0.
- SLT 3<0xFFFFFFFF gives 1; ctrl 4'b1010 gives rsp_data_o=0 and rsp_zero_o=1.
